// File: rtl/pes_fmul_pkg.sv
// ---------------------------------------------------------------------------
// pes_fmul_pkg
// Shared definitions for the sequential shift-add multiplier family.
//   state_e   : controller states (IDLE, CALC, FIN)
//   W_DEFAULT : default operand width
//   clog2()   : counter width for a bit counter running 0..W-1
// ---------------------------------------------------------------------------
package pes_fmul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIN  = 2'd2
   } state_e;

   localparam int W_DEFAULT = 8;

   // Smallest r with 2**r >= v; the bit counter only needs to reach W-1.
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) begin
         r = r + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/pes_signmag.sv
// ---------------------------------------------------------------------------
// pes_signmag
// Conditional two's-complement negate. Used as an absolute-value stage on
// the operands (neg_i = signed mode & operand MSB) and as the final sign
// restore on the 2W-bit product (neg_i = latched result sign).
//   a_i   : input value, W bits
//   neg_i : 1 = output -a_i, 0 = pass a_i through
//   y_o   : result, W bits
// The most negative input maps to itself, which read as unsigned is the
// correct magnitude 2^(W-1).
// ---------------------------------------------------------------------------
module pes_signmag #(
   parameter int W = 8
) (
   input  logic [W-1:0] a_i,
   input  logic         neg_i,
   output logic [W-1:0] y_o
);

   assign y_o = neg_i ? -a_i : a_i;

endmodule

// File: rtl/pes_seqmul.sv
// ---------------------------------------------------------------------------
// pes_seqmul
// Sequential shift-add multiplier, W x W -> 2W, signed or unsigned per
// operation, with a zero-operand early finish.
//   CLK     : rising-edge clock
//   RST     : asynchronous active-high reset
//   St      : start request, honoured only in IDLE
//   Sgn     : 1 = two's-complement operands, 0 = unsigned (sampled with St)
//   Mplier  : multiplier   (sampled with St)
//   Mcand   : multiplicand (sampled with St)
//   Product : 2W-bit result register, changes only on the FIN-entry edge
//   Done    : one-cycle completion pulse (state FIN)
//   Busy    : high from the accept edge through Done
// Magnitudes are multiplied unsigned; the sign is reapplied once at the end.
// ---------------------------------------------------------------------------
module pes_seqmul
   import pes_fmul_pkg::*;
#(
   parameter int W = W_DEFAULT
) (
   input  logic           CLK,
   input  logic           RST,
   input  logic           St,
   input  logic           Sgn,
   input  logic [W-1:0]   Mplier,
   input  logic [W-1:0]   Mcand,
   output logic [2*W-1:0] Product,
   output logic           Done,
   output logic           Busy
);

   localparam int CW = clog2(W);

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q;
   logic [W-1:0]    mplier_q;
   logic [2*W-1:0]  mcand_q;
   logic [2*W-1:0]  acc_q, acc_d;
   logic [2*W-1:0]  product_q;
   logic            neg_q;

   logic [W-1:0]    mplier_abs, mcand_abs;
   logic [2*W-1:0]  prod_fix;
   logic            zero_op;
   logic            last_bit;

   pes_signmag #(.W(W)) u_abs_mplier (
      .a_i   (Mplier),
      .neg_i (Sgn & Mplier[W-1]),
      .y_o   (mplier_abs)
   );

   pes_signmag #(.W(W)) u_abs_mcand (
      .a_i   (Mcand),
      .neg_i (Sgn & Mcand[W-1]),
      .y_o   (mcand_abs)
   );

   // Sign restore acts on the accumulator value including the final add,
   // so Product is written on the same edge as the last CALC step.
   pes_signmag #(.W(2*W)) u_neg_prod (
      .a_i   (acc_d),
      .neg_i (neg_q),
      .y_o   (prod_fix)
   );

   assign zero_op  = (Mplier == '0) || (Mcand == '0);
   assign last_bit = (cnt_q == CW'(W-1));
   assign acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);

   // State register
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (St) state_d = zero_op ? FIN : CALC;
         CALC: if (last_bit) state_d = FIN;
         FIN:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output decode, purely from the state register
   always_comb begin
      Busy = 1'b0;
      Done = 1'b0;
      case (state_q)
         CALC: Busy = 1'b1;
         FIN: begin
            Busy = 1'b1;
            Done = 1'b1;
         end
         default: ;
      endcase
   end

   // Shift-add datapath
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q     <= '0;
         mplier_q  <= '0;
         mcand_q   <= '0;
         acc_q     <= '0;
         neg_q     <= 1'b0;
         product_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (St) begin
                  mplier_q <= mplier_abs;
                  mcand_q  <= {{W{1'b0}}, mcand_abs};
                  acc_q    <= '0;
                  cnt_q    <= '0;
                  neg_q    <= Sgn & (Mplier[W-1] ^ Mcand[W-1]);
                  if (zero_op) begin
                     product_q <= '0;
                  end
               end
            end
            CALC: begin
               acc_q    <= acc_d;
               mplier_q <= mplier_q >> 1;
               mcand_q  <= mcand_q << 1;
               cnt_q    <= cnt_q + CW'(1);
               if (last_bit) begin
                  product_q <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

   assign Product = product_q;

endmodule

// File: tb/tb_pes_seqmul.sv
// ---------------------------------------------------------------------------
// tb_pes_seqmul
// Self-checking bench for pes_seqmul at W=8, W=4 and W=16. Expected products
// come from plain integer multiplication of the (sign-interpreted) operands.
// ---------------------------------------------------------------------------
module tb_pes_seqmul;

   int checks = 0;
   int errors = 0;

   logic CLK = 1'b0;
   logic RST = 1'b1;

   always #5 CLK = ~CLK;

   logic        st8 = 1'b0, sgn8 = 1'b0;
   logic [7:0]  mp8 = '0, mc8 = '0;
   logic [15:0] prod8;
   logic        done8, busy8;

   logic        st4 = 1'b0, sgn4 = 1'b0;
   logic [3:0]  mp4 = '0, mc4 = '0;
   logic [7:0]  prod4;
   logic        done4, busy4;

   logic        st16 = 1'b0, sgn16 = 1'b0;
   logic [15:0] mp16 = '0, mc16 = '0;
   logic [31:0] prod16;
   logic        done16, busy16;

   pes_seqmul #(.W(8)) dut8 (
      .CLK(CLK), .RST(RST), .St(st8), .Sgn(sgn8), .Mplier(mp8), .Mcand(mc8),
      .Product(prod8), .Done(done8), .Busy(busy8));

   pes_seqmul #(.W(4)) dut4 (
      .CLK(CLK), .RST(RST), .St(st4), .Sgn(sgn4), .Mplier(mp4), .Mcand(mc4),
      .Product(prod4), .Done(done4), .Busy(busy4));

   pes_seqmul #(.W(16)) dut16 (
      .CLK(CLK), .RST(RST), .St(st16), .Sgn(sgn16), .Mplier(mp16), .Mcand(mc16),
      .Product(prod16), .Done(done16), .Busy(busy16));

   // Reference: interpret operands as w-bit signed/unsigned integers,
   // multiply, keep the low 2w bits.
   function automatic logic [63:0] ref_mul(input bit s, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
      longint sa, sb, p;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[w-1]) sa = sa - (longint'(1) << w);
      if (s && b[w-1]) sb = sb - (longint'(1) << w);
      p = sa * sb;
      return 64'(p) & ((64'd1 << (2 * w)) - 64'd1);
   endfunction

   // Present operands with St for one cycle; returns #1 after the accept edge.
   task automatic start8(input bit s, input logic [7:0] a, input logic [7:0] b);
      @(negedge CLK);
      sgn8 = s; mp8 = a; mc8 = b; st8 = 1'b1;
      @(posedge CLK);
      #1;
      st8 = 1'b0;
   endtask

   // Edges from "now" until Done is seen (bounded), Busy samples before Done,
   // then one more edge to let FIN return to IDLE and report {Done,Busy}.
   task automatic wait8(output int n, output int busy_n, output logic [1:0] tail);
      n = 0;
      busy_n = 0;
      while (!done8 && n < 100) begin
         if (busy8) busy_n++;
         @(posedge CLK);
         #1;
         n++;
      end
      @(posedge CLK);
      #1;
      tail = {done8, busy8};
   endtask

   task automatic test_reset();
      #2;
      checks++;
      if (prod8 !== 16'h0 || done8 !== 1'b0 || busy8 !== 1'b0) begin
         errors++;
         $display("FAIL reset_w8: prod=%h done=%b busy=%b, required 0000 0 0", prod8, done8, busy8);
      end
      checks++;
      if (prod4 !== 8'h0 || done4 !== 1'b0 || prod16 !== 32'h0 || busy16 !== 1'b0) begin
         errors++;
         $display("FAIL reset_w4_w16: prod4=%h done4=%b prod16=%h busy16=%b, required zeros",
                  prod4, done4, prod16, busy16);
      end
      @(negedge CLK);
      RST = 1'b0;
      @(negedge CLK);
   endtask

   task automatic test_unsigned_max();
      int n, bn;
      logic [1:0] tail;
      logic [15:0] prev;
      bit changed;
      start8(1'b0, 8'd255, 8'd255);
      prev = prod8;
      changed = 1'b0;
      n = 0; bn = 0;
      while (!done8 && n < 100) begin
         if (busy8) bn++;
         if (prod8 !== prev) changed = 1'b1;
         @(posedge CLK);
         #1;
         n++;
      end
      @(posedge CLK);
      #1;
      tail = {done8, busy8};
      checks++;
      if (n != 8 || bn != 8) begin
         errors++;
         $display("FAIL u255x255_latency: done_after=%0d busy_cycles=%0d, required 8 8", n, bn);
      end
      checks++;
      if (prod8 !== 16'hFE01) begin
         errors++;
         $display("FAIL u255x255_product: got %h, required fe01", prod8);
      end
      checks++;
      if (changed || tail !== 2'b00) begin
         errors++;
         $display("FAIL u255x255_stable: product_changed_in_calc=%0d after_done={done,busy}=%b, required 0 00",
                  changed, tail);
      end
   endtask

   task automatic test_signed();
      logic [7:0]  a_t[3] = '{8'h80, 8'h80, 8'd25};
      logic [7:0]  b_t[3] = '{8'h80, 8'h7F, 8'hFB};
      logic [15:0] e_t[3] = '{16'h4000, 16'hC080, 16'hFF83};
      int n, bn;
      logic [1:0] tail;
      for (int i = 0; i < 3; i++) begin
         start8(1'b1, a_t[i], b_t[i]);
         wait8(n, bn, tail);
         checks++;
         if (prod8 !== e_t[i] || prod8 !== ref_mul(1'b1, 32'(a_t[i]), 32'(b_t[i]), 8) || n != 8) begin
            errors++;
            $display("FAIL signed_case%0d: %h*%h got %h after %0d cycles, required %h after 8",
                     i, a_t[i], b_t[i], prod8, n, e_t[i]);
         end
      end
   endtask

   task automatic test_zero_shortcut();
      int n, bn;
      logic [1:0] tail;
      start8(1'b0, 8'd128, 8'd0);
      wait8(n, bn, tail);
      checks++;
      if (n != 0 || prod8 !== 16'h0 || tail !== 2'b00) begin
         errors++;
         $display("FAIL zero_128x0: done_after=%0d prod=%h tail=%b, required 0 0000 00", n, prod8, tail);
      end
      // Make Product non-zero so the second shortcut has something to clear.
      start8(1'b0, 8'd3, 8'd5);
      wait8(n, bn, tail);
      checks++;
      if (prod8 !== 16'd15) begin
         errors++;
         $display("FAIL zero_interlude_3x5: got %0d, required 15", prod8);
      end
      start8(1'b1, 8'd0, 8'd77);
      wait8(n, bn, tail);
      checks++;
      if (n != 0 || prod8 !== 16'h0 || tail !== 2'b00) begin
         errors++;
         $display("FAIL zero_0x77: done_after=%0d prod=%h tail=%b, required 0 0000 00", n, prod8, tail);
      end
   endtask

   task automatic test_start_ignored();
      int n, bn, extra;
      logic [1:0] tail;
      start8(1'b0, 8'd11, 8'd33);
      repeat (3) @(negedge CLK);
      mp8 = 8'd80; mc8 = 8'd10; st8 = 1'b1;
      @(posedge CLK);
      #1;
      st8 = 1'b0;
      wait8(n, bn, tail);
      checks++;
      if (prod8 !== 16'd363 || n != 5) begin
         errors++;
         $display("FAIL ignore_first: got %0d done_after=%0d, required 363 5", prod8, n);
      end
      extra = 0;
      for (int i = 0; i < 12; i++) begin
         if (done8 || busy8) extra++;
         @(posedge CLK);
         #1;
      end
      checks++;
      if (extra != 0 || tail !== 2'b00 || prod8 !== 16'd363) begin
         errors++;
         $display("FAIL ignore_no_second: activity_cycles=%0d prod=%0d, required 0 363", extra, prod8);
      end
      start8(1'b0, 8'd80, 8'd10);
      wait8(n, bn, tail);
      checks++;
      if (prod8 !== 16'd800 || n != 8) begin
         errors++;
         $display("FAIL ignore_fresh: got %0d after %0d, required 800 after 8", prod8, n);
      end
   endtask

   task automatic test_async_reset();
      int n, bn, leak;
      logic [1:0] tail;
      start8(1'b0, 8'd64, 8'd64);
      repeat (4) @(posedge CLK);
      #3;
      RST = 1'b1;
      #1;
      checks++;
      if (prod8 !== 16'h0 || busy8 !== 1'b0 || done8 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: prod=%h busy=%b done=%b, required 0000 0 0", prod8, busy8, done8);
      end
      @(negedge CLK);
      RST = 1'b0;
      leak = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge CLK);
         #1;
         if (done8 || busy8 || prod8 !== 16'h0) leak++;
      end
      checks++;
      if (leak != 0) begin
         errors++;
         $display("FAIL async_reset_leak: cycles_with_activity=%0d, required 0", leak);
      end
      start8(1'b0, 8'd36, 8'd36);
      wait8(n, bn, tail);
      checks++;
      if (prod8 !== 16'd1296 || n != 8) begin
         errors++;
         $display("FAIL async_reset_after: got %0d after %0d, required 1296 after 8", prod8, n);
      end
   endtask

   task automatic test_w4();
      int n;
      @(negedge CLK);
      sgn4 = 1'b0; mp4 = 4'd15; mc4 = 4'd15; st4 = 1'b1;
      @(posedge CLK);
      #1;
      st4 = 1'b0;
      n = 0;
      while (!done4 && n < 100) begin
         @(posedge CLK);
         #1;
         n++;
      end
      checks++;
      if (prod4 !== 8'hE1 || n != 4) begin
         errors++;
         $display("FAIL w4_15x15: got %h after %0d, required e1 after 4", prod4, n);
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic test_w16_sweep();
      logic [15:0] edge_v[5] = '{16'h8000, 16'h7FFF, 16'hFFFF, 16'h0000, 16'h0001};
      logic [15:0] a, b;
      logic [31:0] exp_p;
      bit s;
      int n, exp_n;
      for (int i = 0; i < 1000; i++) begin
         s = 1'($urandom_range(0, 1));
         a = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
         b = ($urandom_range(0, 7) == 0) ? edge_v[$urandom_range(0, 4)] : 16'($urandom);
         exp_p = 32'(ref_mul(s, 32'(a), 32'(b), 16));
         exp_n = (a == 16'h0 || b == 16'h0) ? 0 : 16;
         @(negedge CLK);
         sgn16 = s; mp16 = a; mc16 = b; st16 = 1'b1;
         @(posedge CLK);
         #1;
         st16 = 1'b0;
         sgn16 = ~s; mp16 = 16'($urandom); mc16 = 16'($urandom);
         n = 0;
         while (!done16 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
         end
         checks++;
         if (prod16 !== exp_p || n != exp_n) begin
            errors++;
            $display("FAIL w16_sweep[%0d]: sgn=%0d %h*%h got %h after %0d, required %h after %0d",
                     i, s, a, b, prod16, n, exp_p, exp_n);
         end
         @(posedge CLK);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_unsigned_max();
      test_signed();
      test_zero_shortcut();
      test_start_ignored();
      test_async_reset();
      test_w4();
      test_w16_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
